vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Transaction controller for the vending machine datapath. Takes debounced coin pulses, keeps the
//  escrow credit, and starts item release once credit reaches PRICE. It then pays the change one
//  coin at a time through a req/ack hopper handshake. A watchdog moves it to a sticky FAULT state.
// PARAMETERS
//  CW          4    width of credit/change regs; unit = 25c (F25=1, H50=2, P1=4)
//  PRICE       3    item price in 25c units (3 = 75c); 1 <= PRICE <= MAX_CREDIT
//  MAX_CREDIT  8    max escrow credit; any coin that would exceed it is rejected
//  ACK_TIMEOUT 1000 cycles to wait for item_ack/hop_ack before FAULT
// PORTS
//  CLK          in   1    system clock; all logic on rising edge
//  Reset        in   1    synchronous, active-low reset
//  coin_p1      in   1    1-cycle pulse: $1 coin inserted
//  coin_h50     in   1    1-cycle pulse: 50c coin inserted
//  coin_f25     in   1    1-cycle pulse: 25c coin inserted
//  cancel       in   1    1-cycle pulse: refund all credit
//  item_req     out  1    request item release; held until item_ack
//  item_ack     in   1    item released
//  hop_req      out  1    request one change coin; held until hop_ack
//  hop_sel      out  2    coin type for hop_req: 2'b01=50c, 2'b10=25c, 2'b00 when idle
//  hop_ack      in   1    hopper dispensed the coin on hop_sel
//  credit       out  CW   current escrow credit (to seg7 display)
//  change_rem   out  CW   change still owed
//  coin_reject  out  1    1-cycle pulse: coin dropped in this cycle, returned mechanically
//  fault        out  1    sticky watchdog fault
//  state        out  3    state code (COLLECT=0, VEND=1, CHG_REQ=2, CHG_GAP=3, FAULT=7)
// BEHAVIOUR
//  - All outputs are registered (Moore). Reset=0 at an edge clears everything to 0 and sets state
//    COLLECT, including mid-handshake. item_req and hop_req go low on that same edge.
//  - COLLECT, coin accept: one coin per cycle, priority P1 > H50 > F25. Other coins in that
//    cycle are dropped and coin_reject pulses.
//  - COLLECT, credit limit: a coin with credit+value > MAX_CREDIT is rejected (coin_reject,
//    credit unchanged).
//  - COLLECT, timing: coin pulse at cycle N -> credit updated at N+1. If the registered credit
//    >= PRICE, the next edge enters VEND, so item_req=1 at N+2.
//  - COLLECT, cancel: cancel with credit>0 -> change_rem=credit, credit=0, go to CHG_REQ.
//    Cancel with credit=0 is ignored. Cancel and a coin in the same cycle: cancel wins and the
//    coin is rejected.
//  - VEND/CHG_*: every coin is rejected; cancel is ignored.
//  - VEND: item_req=1. On item_ack: change_rem=credit-PRICE, credit=0, item_req=0.
//    Go to CHG_REQ if change_rem>0, else COLLECT.
//  - CHG_REQ: hop_req=1; hop_sel=50c if change_rem>=2, else 25c. hop_sel stays stable while
//    hop_req is high. On hop_ack: change_rem -= 2 or 1, hop_req=0, go to CHG_GAP.
//  - CHG_GAP: exactly 1 cycle with hop_req=0 and hop_sel=0. Then go to COLLECT if
//    change_rem==0, else CHG_REQ.
//  - An ack that arrives while the matching req is low is ignored.
//  - Watchdog: counter clears on every state entry and counts while in VEND or CHG_REQ. When it
//    reaches ACK_TIMEOUT with no ack: go to FAULT, fault=1, all reqs low, credit and change_rem
//    frozen. Only Reset leaves FAULT.
//  - Arithmetic: unsigned CW-bit; MAX_CREDIT < 2**CW, so no wrap is possible.
// TESTING
//  T1 Reset low 1 edge mid-CHG_REQ -> next cycle hop_req=0, credit=0, change_rem=0, state=0.
//  T2 F25 x3 (PRICE=3) -> credit 1,2,3; item_req=1 two cycles after the 3rd pulse;
//     item_ack -> credit=0, no hop_req, state=0.
//  T3 P1 -> credit=4, VEND; item_ack -> change_rem=1; one handshake with hop_sel=2'b10;
//     then COLLECT.
//  T4 H50 then P1 -> credit 6; VEND; ack -> change_rem=3 -> hop_sel=01 handshake,
//     1-cycle gap, hop_sel=10 handshake -> change_rem=0.
//  T5 P1+F25 in the same cycle -> credit=4, coin_reject pulse; coin during VEND -> rejected;
//     H50 at credit 0 then cancel -> one 50c handshake.
//  T6 hold hop_ack=0 for ACK_TIMEOUT cycles -> fault=1, state=7, hop_req=0;
//     coins are ignored; Reset -> fault=0.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending machine transaction controller: escrow credit, item vend,
// coin-by-coin change payout over a req/ack hopper, watchdog fault.
module vend_sequencer #(
   parameter int CW          = 4,
   parameter int PRICE       = 3,
   parameter int MAX_CREDIT  = 8,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          coin_p1,
   input  logic          coin_h50,
   input  logic          coin_f25,
   input  logic          cancel,
   output logic          item_req,
   input  logic          item_ack,
   output logic          hop_req,
   output logic [1:0]    hop_sel,
   input  logic          hop_ack,
   output logic [CW-1:0] credit,
   output logic [CW-1:0] change_rem,
   output logic          coin_reject,
   output logic          fault,
   output logic [2:0]    state
);

   typedef enum logic [2:0] {
      COLLECT = 3'd0,
      VEND    = 3'd1,
      CHG_REQ = 3'd2,
      CHG_GAP = 3'd3,
      FAULT   = 3'd7
   } st_t;

   localparam int WW = $clog2(ACK_TIMEOUT + 1);

   st_t           st;
   logic [WW-1:0] wd;
   logic          any_coin;
   logic          multi;
   logic [CW:0]   coin_val;
   logic [CW:0]   sum;
   logic          wd_hit;
   logic [CW-1:0] vend_chg;
   logic [CW-1:0] dec;

   assign state = st;

   // Highest-priority coin only; any others in the same cycle are dropped
   always_comb begin
      coin_val = '0;
      if (coin_p1)
         coin_val = (CW+1)'(4);
      else if (coin_h50)
         coin_val = (CW+1)'(2);
      else if (coin_f25)
         coin_val = (CW+1)'(1);
   end

   assign any_coin = coin_p1 | coin_h50 | coin_f25;
   assign multi    = (coin_p1 & (coin_h50 | coin_f25)) | (coin_h50 & coin_f25);
   assign sum      = {1'b0, credit} + coin_val;
   assign wd_hit   = (wd == WW'(ACK_TIMEOUT - 1));
   assign vend_chg = credit - CW'(PRICE);
   assign dec      = (hop_sel == 2'b01) ? CW'(2) : CW'(1);

   function automatic logic [1:0] sel_for(input logic [CW-1:0] c);
      return (c >= CW'(2)) ? 2'b01 : 2'b10;
   endfunction

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         st          <= COLLECT;
         wd          <= '0;
         credit      <= '0;
         change_rem  <= '0;
         item_req    <= 1'b0;
         hop_req     <= 1'b0;
         hop_sel     <= 2'b00;
         coin_reject <= 1'b0;
         fault       <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         wd          <= '0;
         unique case (st)
            COLLECT: begin
               if (cancel && credit != '0) begin
                  change_rem  <= credit;
                  credit      <= '0;
                  hop_req     <= 1'b1;
                  hop_sel     <= sel_for(credit);
                  st          <= CHG_REQ;
                  coin_reject <= any_coin;
               end else if (credit >= CW'(PRICE)) begin
                  item_req    <= 1'b1;
                  st          <= VEND;
                  coin_reject <= any_coin;
               end else if (any_coin) begin
                  if (sum <= (CW+1)'(MAX_CREDIT)) begin
                     credit      <= sum[CW-1:0];
                     coin_reject <= multi;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end
            VEND: begin
               coin_reject <= any_coin;
               if (item_ack) begin
                  item_req   <= 1'b0;
                  credit     <= '0;
                  change_rem <= vend_chg;
                  if (vend_chg != '0) begin
                     hop_req <= 1'b1;
                     hop_sel <= sel_for(vend_chg);
                     st      <= CHG_REQ;
                  end else begin
                     st <= COLLECT;
                  end
               end else if (wd_hit) begin
                  item_req <= 1'b0;
                  fault    <= 1'b1;
                  st       <= FAULT;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            CHG_REQ: begin
               coin_reject <= any_coin;
               if (hop_ack) begin
                  change_rem <= change_rem - dec;
                  hop_req    <= 1'b0;
                  hop_sel    <= 2'b00;
                  st         <= CHG_GAP;
               end else if (wd_hit) begin
                  hop_req <= 1'b0;
                  hop_sel <= 2'b00;
                  fault   <= 1'b1;
                  st      <= FAULT;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            CHG_GAP: begin
               coin_reject <= any_coin;
               if (change_rem == '0) begin
                  st <= COLLECT;
               end else begin
                  hop_req <= 1'b1;
                  hop_sel <= sel_for(change_rem);
                  st      <= CHG_REQ;
               end
            end
            FAULT: begin
               st <= FAULT;
            end
            default: begin
               st <= COLLECT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with a transaction-level model
// checked every cycle, plus hand-computed literal expectations.
module tb_vend_sequencer;

   localparam int CW  = 4;
   localparam int PR  = 3;
   localparam int MX  = 8;
   localparam int TMO = 1000;

   logic          CLK = 1'b0;
   logic          Reset = 1'b0;
   logic          coin_p1 = 1'b0, coin_h50 = 1'b0, coin_f25 = 1'b0;
   logic          cancel = 1'b0, item_ack = 1'b0, hop_ack = 1'b0;
   logic          item_req, hop_req, coin_reject, fault;
   logic [1:0]    hop_sel;
   logic [CW-1:0] credit, change_rem;
   logic [2:0]    state;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // model: transaction phase, escrow, owed change, wait cycles
   int m_ph = 0;
   int m_credit = 0;
   int m_change = 0;
   int m_wait = 0;
   int m_rej = 0;

   vend_sequencer #(
      .CW(CW), .PRICE(PR), .MAX_CREDIT(MX), .ACK_TIMEOUT(TMO)
   ) dut (
      .CLK(CLK), .Reset(Reset),
      .coin_p1(coin_p1), .coin_h50(coin_h50), .coin_f25(coin_f25),
      .cancel(cancel),
      .item_req(item_req), .item_ack(item_ack),
      .hop_req(hop_req), .hop_sel(hop_sel), .hop_ack(hop_ack),
      .credit(credit), .change_rem(change_rem),
      .coin_reject(coin_reject), .fault(fault), .state(state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int n;
      int v;
      n = int'(coin_p1) + int'(coin_h50) + int'(coin_f25);
      m_rej = 0;
      if (!Reset) begin
         m_ph = 0; m_credit = 0; m_change = 0; m_wait = 0;
         return;
      end
      case (m_ph)
         0: begin
            m_rej = (n > 0) ? 1 : 0;
            if (cancel && m_credit > 0) begin
               m_change = m_credit; m_credit = 0;
               m_ph = 2; m_wait = 0;
            end else if (m_credit >= PR) begin
               m_ph = 1; m_wait = 0;
            end else if (n > 0) begin
               v = coin_p1 ? 4 : (coin_h50 ? 2 : 1);
               if (m_credit + v <= MX) begin
                  m_credit += v;
                  m_rej = (n > 1) ? 1 : 0;
               end
            end
         end
         1: begin
            m_rej = (n > 0) ? 1 : 0;
            if (item_ack) begin
               m_change = m_credit - PR; m_credit = 0;
               m_ph = (m_change > 0) ? 2 : 0; m_wait = 0;
            end else begin
               m_wait++;
               if (m_wait == TMO) m_ph = 7;
            end
         end
         2: begin
            m_rej = (n > 0) ? 1 : 0;
            if (hop_ack) begin
               m_change -= (m_change >= 2) ? 2 : 1;
               m_ph = 3; m_wait = 0;
            end else begin
               m_wait++;
               if (m_wait == TMO) m_ph = 7;
            end
         end
         3: begin
            m_rej = (n > 0) ? 1 : 0;
            m_ph = (m_change == 0) ? 0 : 2;
            m_wait = 0;
         end
         default: ;
      endcase
   endtask

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("state", int'(state), m_ph);
         chk("credit", int'(credit), m_credit);
         chk("change_rem", int'(change_rem), m_change);
         chk("item_req", int'(item_req), (m_ph == 1) ? 1 : 0);
         chk("hop_req", int'(hop_req), (m_ph == 2) ? 1 : 0);
         chk("hop_sel", int'(hop_sel),
             (m_ph == 2) ? ((m_change >= 2) ? 1 : 2) : 0);
         chk("fault", int'(fault), (m_ph == 7) ? 1 : 0);
         chk("coin_reject", int'(coin_reject), m_rej);
      end
   end

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
      coin_p1 = 0; coin_h50 = 0; coin_f25 = 0;
      cancel = 0; item_ack = 0; hop_ack = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      Reset = 0;
      tick();
      chk_en = 1;
      tick();
      Reset = 1;
      chk("rst_state", int'(state), 0);
      chk("rst_credit", int'(credit), 0);
      chk("rst_fault", int'(fault), 0);

      // T2: three quarters
      coin_f25 = 1; tick();
      chk("t2_c1", int'(credit), 1);
      coin_f25 = 1; tick();
      chk("t2_c2", int'(credit), 2);
      coin_f25 = 1; tick();
      chk("t2_c3", int'(credit), 3);
      chk("t2_noreq", int'(item_req), 0);
      tick();
      chk("t2_req", int'(item_req), 1);
      tick();
      item_ack = 1; tick();
      chk("t2_credit0", int'(credit), 0);
      chk("t2_state0", int'(state), 0);
      chk("t2_nohop", int'(hop_req), 0);

      // acks while reqs are low are ignored
      hop_ack = 1; item_ack = 1; tick();
      chk("stray_ack", int'(state), 0);

      // T3: $1, one quarter change
      coin_p1 = 1; tick();
      chk("t3_c4", int'(credit), 4);
      tick();
      item_ack = 1; tick();
      chk("t3_chg", int'(change_rem), 1);
      chk("t3_sel", int'(hop_sel), 2);
      ticks(2);
      hop_ack = 1; tick();
      chk("t3_gap", int'(state), 3);
      tick();
      chk("t3_done", int'(state), 0);

      // T4: 50c + $1, change 75c as 50c then 25c
      coin_h50 = 1; tick();
      coin_p1 = 1; tick();
      chk("t4_c6", int'(credit), 6);
      tick();
      item_ack = 1; tick();
      chk("t4_chg3", int'(change_rem), 3);
      chk("t4_sel50", int'(hop_sel), 1);
      hop_ack = 1; tick();
      chk("t4_gapsel", int'(hop_sel), 0);
      tick();
      chk("t4_sel25", int'(hop_sel), 2);
      hop_ack = 1; tick();
      chk("t4_chg0", int'(change_rem), 0);
      tick();

      // T5: simultaneous coins, coin in VEND, cancel refunds
      coin_p1 = 1; coin_f25 = 1; tick();
      chk("t5_c4", int'(credit), 4);
      chk("t5_rej", int'(coin_reject), 1);
      tick();
      coin_h50 = 1; tick();
      chk("t5_vendrej", int'(coin_reject), 1);
      chk("t5_vendcred", int'(credit), 4);
      item_ack = 1; tick();
      hop_ack = 1; tick();
      tick();
      cancel = 1; tick();
      chk("t5_cancel0", int'(state), 0);
      coin_h50 = 1; tick();
      cancel = 1; tick();
      chk("t5_refund", int'(change_rem), 2);
      chk("t5_refsel", int'(hop_sel), 1);
      hop_ack = 1; tick();
      tick();
      coin_f25 = 1; tick();
      cancel = 1; coin_h50 = 1; tick();
      chk("t5_cxl_win", int'(change_rem), 1);
      chk("t5_cxl_rej", int'(coin_reject), 1);
      hop_ack = 1; tick();
      tick();

      // T1: reset in the middle of a hopper handshake
      coin_f25 = 1; tick();
      cancel = 1; tick();
      chk("t1_hop", int'(hop_req), 1);
      Reset = 0; tick();
      Reset = 1;
      chk("t1_hop0", int'(hop_req), 0);
      chk("t1_chg0", int'(change_rem), 0);
      chk("t1_state", int'(state), 0);

      // T6: hopper watchdog
      coin_p1 = 1; tick();
      tick();
      item_ack = 1; tick();
      ticks(TMO - 1);
      chk("t6_prefault", int'(state), 2);
      tick();
      chk("t6_state7", int'(state), 7);
      chk("t6_fault", int'(fault), 1);
      chk("t6_hop0", int'(hop_req), 0);
      coin_p1 = 1; tick();
      chk("t6_frozen", int'(change_rem), 1);
      chk("t6_nocred", int'(credit), 0);
      ticks(3);
      Reset = 0; tick();
      Reset = 1;
      chk("t6_clear", int'(fault), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
